// File: rtl/miner_pkg.sv
// Shared miner-core definitions: work frame geometry, field offsets, rx FSM states.
package miner_pkg;

  localparam int WORK_BYTES = 84;
  localparam int WORK_BITS  = 8 * WORK_BYTES;

  // Field layout inside the assembled work word
  localparam int TARGET_MSB = 671;
  localparam int TARGET_LSB = 640;
  localparam int NONCE_MSB  = 639;
  localparam int NONCE_LSB  = 608;
  localparam int DATA_MSB   = 607;
  localparam int DATA_LSB   = 0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Clock cycles per serial bit, rounded to nearest
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, start/data/stop sampling FSM.
module uart_rx_byte
  import miner_pkg::*;
#(
  parameter int BIT_CYCLES = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       stop_err,
  output logic       start_edge,
  output logic       in_idle,
  output logic       byte_active
);

  localparam int HALF = BIT_CYCLES / 2;
  localparam int TW   = $clog2(BIT_CYCLES + 1);

  logic            rx_s1, rxs, rxs_d;
  rx_state_t       state, state_nx;
  logic [TW-1:0]   tmr, tmr_nx;
  logic [2:0]      bit_idx, bit_idx_nx;
  logic [7:0]      sh, sh_nx;
  logic            strobe_nx, err_nx;

  // A start is only recognised on a 1->0 transition, so after a bad stop
  // bit the line must return high before the next byte can begin.
  assign start_edge  = (state == RX_IDLE) && rxs_d && !rxs;
  assign in_idle     = (state == RX_IDLE);
  assign byte_active = (state == RX_DATA) || (state == RX_STOP);
  assign rx_byte     = sh;

  // Synchroniser, state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1       <= 1'b1;
      rxs         <= 1'b1;
      rxs_d       <= 1'b1;
      state       <= RX_IDLE;
      tmr         <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      byte_strobe <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      rx_s1       <= RxD;
      rxs         <= rx_s1;
      rxs_d       <= rxs;
      state       <= state_nx;
      tmr         <= tmr_nx;
      bit_idx     <= bit_idx_nx;
      sh          <= sh_nx;
      byte_strobe <= strobe_nx;
      stop_err    <= err_nx;
    end
  end

  // Next-state: half-bit wait to centre on the start bit, then full-bit steps
  always_comb begin
    state_nx   = state;
    tmr_nx     = tmr;
    bit_idx_nx = bit_idx;
    sh_nx      = sh;
    strobe_nx  = 1'b0;
    err_nx     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (start_edge) begin
          state_nx = RX_START;
          tmr_nx   = TW'(HALF - 1);
        end
      end
      RX_START: begin
        if (tmr != '0)  tmr_nx = tmr - 1'b1;
        else if (rxs)   state_nx = RX_IDLE;   // glitch, silently ignored
        else begin
          state_nx   = RX_DATA;
          tmr_nx     = TW'(BIT_CYCLES - 1);
          bit_idx_nx = '0;
        end
      end
      RX_DATA: begin
        if (tmr != '0) tmr_nx = tmr - 1'b1;
        else begin
          sh_nx  = {rxs, sh[7:1]};
          tmr_nx = TW'(BIT_CYCLES - 1);
          if (bit_idx == 3'd7) state_nx = RX_STOP;
          else                 bit_idx_nx = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (tmr != '0) tmr_nx = tmr - 1'b1;
        else begin
          state_nx = RX_IDLE;
          if (rxs) strobe_nx = 1'b1;
          else     err_nx    = 1'b1;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/work_receive.sv
// Work assembler: collects num_bytes UART bytes into one work word, with
// stop-bit and inter-byte gap guarding so partial frames never reach the core.
module work_receive
  import miner_pkg::*;
#(
  parameter int comm_clk_frequency = 100_000_000,
  parameter int baud_rate          = 115_200,
  parameter int num_bytes          = WORK_BYTES,
  parameter int gap_bits           = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RxD,
  output logic [8*num_bytes-1:0] work_data,
  output logic                   work_valid,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam int BIT_CYCLES = bit_cycles(comm_clk_frequency, baud_rate);
  localparam int GAP_LIMIT  = gap_bits * BIT_CYCLES;
  localparam int GW         = $clog2(GAP_LIMIT + 1);
  localparam int CW         = $clog2(num_bytes + 1);
  localparam int NB         = 8 * num_bytes;

  logic [7:0]    rx_byte;
  logic          byte_strobe, stop_err, start_edge, in_idle, byte_active;
  logic [NB-1:0] shreg;
  logic [CW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic          gap_hit;

  uart_rx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .RxD         (RxD),
    .rx_byte     (rx_byte),
    .byte_strobe (byte_strobe),
    .stop_err    (stop_err),
    .start_edge  (start_edge),
    .in_idle     (in_idle),
    .byte_active (byte_active)
  );

  // Timeout fires on the cycle the idle count would reach the limit; it is
  // checked ahead of the start edge so a coinciding new byte starts frame byte 0.
  assign gap_hit = in_idle && (byte_cnt != '0) && (gap_cnt == GW'(GAP_LIMIT - 1));
  assign rx_busy = (byte_cnt != '0) || byte_active;

  // Byte counting, gap timing, assembly and whole-frame publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      work_data  <= '0;
      work_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      work_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (stop_err || gap_hit) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
        gap_cnt   <= '0;
      end else if (byte_strobe) begin
        shreg   <= {shreg[NB-9:0], rx_byte};
        gap_cnt <= '0;
        if (byte_cnt == CW'(num_bytes - 1)) begin
          work_data  <= {shreg[NB-9:0], rx_byte};
          work_valid <= 1'b1;
          byte_cnt   <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (start_edge) begin
        gap_cnt <= '0;
      end else if (in_idle && (byte_cnt != '0)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/work_receive.md
Name: work_receive

Overview:
- Upstream stage of the miner core: UART receiver plus work assembler.
- Deserialises the host's 84-byte getwork over RxD into a 672-bit work word.
- Pulses work_valid when a complete frame arrives; the hashing core loads data/target/nonce from work_data.
- Guards against partial frames with an inter-byte gap timeout and stop-bit checking.

Parameters:
- comm_clk_frequency, 100_000_000, clk frequency in Hz.
- baud_rate, 115_200, serial bit rate.
- num_bytes, 84, bytes per work frame.
- gap_bits, 64, idle bit-periods mid-frame before the partial frame is discarded.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- RxD  input  1  serial line, idle high, 8N1, LSB first, asynchronous to clk.
- work_data  output  8*num_bytes  last complete frame; first received byte in [671:664], last in [7:0].
- work_valid  output  1  one-cycle pulse, work_data updated on the same edge.
- frame_err  output  1  one-cycle pulse on bad stop bit or gap timeout mid-frame.
- rx_busy  output  1  high while a frame is partially received (byte count nonzero or byte in progress).

Behaviour:
- Reset is asynchronous and active-low. All state clears: work_data=0, work_valid=0, frame_err=0, rx_busy=0, byte count=0, FSM=IDLE, synchroniser flops=1.
- BIT_CYCLES = (comm_clk_frequency + baud_rate/2)/baud_rate, which is 9 at 1 MHz / 115200. HALF = BIT_CYCLES/2.
- RxD passes through a 2-flop synchroniser, reset to 1. All decisions use the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: falling rxs (1 to 0) loads the bit counter and moves to START.
  - START: samples at HALF cycles. If rxs=1, the start was a glitch: return to IDLE with no error. Otherwise move to DATA.
  - DATA: samples at each further BIT_CYCLES, 8 samples, shifting in LSB first.
  - STOP: samples at BIT_CYCLES.
    - rxs=1: the byte is accepted into the shift register at the 8-bit slot, count increments, FSM returns to IDLE.
    - rxs=0: frame_err pulses, byte count clears, assembled bytes are discarded, FSM returns to IDLE. It then waits for rxs=1 before detecting a new start.
- Byte assembly: 672-bit shift register, shifting left by 8 with the new byte in [7:0].
- Frame completion: when the accepted byte makes count==num_bytes:
  - On the next edge work_data <= shift register and work_valid=1 for one cycle.
  - Count wraps to 0.
  - Latency is 1 clk after the stop-bit sample.
- work_data holds its value between frames. It is never partially updated.
- Gap timer:
  - Counts cycles in IDLE while count!=0. It clears on each start edge.
  - Reaching gap_bits*BIT_CYCLES pulses frame_err and clears count.
  - When count==0 the timer is inactive and no error is raised.
- Simultaneous timeout and start edge in the same cycle: the timeout wins. The count clears and the new byte begins frame byte 0.
- Reset mid-byte or mid-frame discards everything. No work_valid is produced for a partial frame.
- Counter widths: $clog2(gap_bits*BIT_CYCLES+1) for the timer and $clog2(num_bytes+1) for the byte count. No overflow is possible.

Decomposition:
- Shared package (miner_pkg) holds:
  - WORK_BYTES=84, WORK_BITS=672.
  - Field offsets inside work_data: target [671:640], nonce [639:608], data [607:0].
  - rx FSM state enum.
- Natural sub-module: uart_rx_byte. It contains the synchroniser, IDLE/START/DATA/STOP FSM and bit timer, and outputs byte, byte_strobe and stop_err.
- work_receive adds the byte counter, gap timer and 672-bit assembly around it.

Test Plan:
- Single frame, comm_clk_frequency=1_000_000, 84 bytes:
  - Stimulus: the value 000007ff0000318e7e71...01000000, sent MSB byte first, back-to-back.
  - Response: exactly one work_valid; work_data equals the sent value; work_data[639:608]=32'h0000318e.
- Glitch:
  - Stimulus: RxD low for 2 cycles (less than HALF) in IDLE.
  - Response: no byte accepted, no frame_err, rx_busy stays 0.
- Bad stop bit:
  - Stimulus: byte 10 sent with stop=0, then a full valid 84-byte frame.
  - Response: frame_err pulse once; one work_valid carrying only the second frame.
- Gap timeout:
  - Stimulus: 40 bytes, idle 64*9+5 cycles, then 84 bytes.
  - Response: frame_err at exactly 576 idle cycles; work_valid carries the 84-byte frame.
- Reset mid-frame:
  - Stimulus: rst_n low during byte 50, then a new 84-byte frame.
  - Response: outputs 0 during reset; one correct work_valid afterwards.
- Two consecutive frames with no gap:
  - Response: two work_valid pulses; work_data equals frame 2 after the second pulse.
